// File: rtl/io_spi_pkg.sv
// Shared definitions for the FMC151 SPI bus arbiter: device indices,
// per-device word lengths, FSM state encoding and a one-hot decode helper.
package io_spi_pkg;

  localparam int NUM_DEV = 4;
  localparam int WORD_W  = 32;

  // Device index on req/done/spi_n_en and word slot in wdata.
  localparam logic [1:0] DEV_CDCE = 2'd0;
  localparam logic [1:0] DEV_ADS  = 2'd1;
  localparam logic [1:0] DEV_DAC  = 2'd2;
  localparam logic [1:0] DEV_AMC  = 2'd3;

  // Bits sent per device, taken MSB-first from the top of its word.
  localparam logic [5:0] DEV_LEN [NUM_DEV] = '{6'd32, 6'd16, 6'd16, 6'd32};

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // Index of the set bit in a one-hot grant vector (0 when none is set).
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_DEV-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_spi_arbiter_if.sv
// Requester-side bundle of the SPI arbiter: request levels, the four
// left-justified write words, completion pulses, busy and readback word.
interface io_spi_arbiter_if;
  import io_spi_pkg::*;

  logic [NUM_DEV-1:0]        req;
  logic [NUM_DEV*WORD_W-1:0] wdata;
  logic [NUM_DEV-1:0]        done;
  logic                      busy;
  logic [WORD_W-1:0]         rdata;

  // Configuration sequencers drive requests and data.
  modport master (output req, wdata, input done, busy, rdata);
  // The arbiter consumes requests and reports completion.
  modport slave (input req, wdata, output done, busy, rdata);
endinterface

// File: rtl/io_spi_rr_arbiter.sv
// 4-way round-robin grant. The search starts at the pointer and takes the
// first high request; on advance the pointer moves to one past the winner.
module io_spi_rr_arbiter
  import io_spi_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DEV-1:0] req,
  input  logic               advance,
  output logic [NUM_DEV-1:0] grant,
  output logic               valid
);

  logic [1:0]           ptr;
  logic [2*NUM_DEV-1:0] req_dbl;
  logic [NUM_DEV-1:0]   req_rot;
  logic [1:0]           off;
  logic [1:0]           win;

  // Rotate requests so the pointer position is bit 0, then pick the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: NUM_DEV];
    off     = 2'd0;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      if (req_rot[k]) off = 2'(k);
    end
    win   = ptr + off;
    valid = |req;
    grant = valid ? (4'b0001 << win) : 4'b0000;
  end

  // Pointer moves past the winner only when the grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (advance && valid) begin
      ptr <= win + 2'd1;
    end
  end

endmodule

// File: rtl/io_spi_arbiter.sv
// Shares the FMC151 SPI bus between CDCE, ADS, DAC and AMC configuration
// sequencers. Grants round-robin, drives the selected active-low enable and
// shifts the fixed-length word out MSB-first with CPOL=0 timing.
// Optional MISO capture is compiled in with IO_SPI_READBACK_EN.
module io_spi_arbiter
  import io_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,  // clk cycles per SCLK half-period, >= 2
  parameter int CS_GAP  = 8   // idle cycles with all enables high, >= 1
) (
  input  logic               clk,
  input  logic               rst_n,
  io_spi_arbiter_if.slave    bus,
  output logic               spi_sclk,
  output logic               spi_sdata,
  input  logic               spi_miso,
  output logic [NUM_DEV-1:0] spi_n_en
);

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        cnt;       // cycle within a half-period, or within GAP
  logic [6:0]         half;      // SHIFT half-period number, 1..2*LEN
  logic [5:0]         len_r;
  logic [NUM_DEV-1:0] grant_r;
  logic [WORD_W-1:0]  shreg;     // bits still to be sent, next one at [31]

  logic [NUM_DEV-1:0] rr_grant;
  logic               rr_valid;
  logic [1:0]         win_idx;
  logic [WORD_W-1:0]  win_word;
  logic               half_end;
  logic               gap_end;
  logic               last_half;

  io_spi_rr_arbiter u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .advance (state == IDLE),
    .grant   (rr_grant),
    .valid   (rr_valid)
  );

  assign win_idx   = onehot_to_idx(rr_grant);
  assign win_word  = bus.wdata[{win_idx, 5'b0} +: WORD_W];
  assign half_end  = (cnt == HALF_LAST);
  assign gap_end   = (cnt == GAP_LAST);
  assign last_half = (half == {len_r, 1'b0});

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rr_valid) state_nxt = SETUP;
      SETUP:   if (half_end) state_nxt = SHIFT;
      SHIFT:   if (half_end && last_half) state_nxt = HOLD;
      HOLD:    if (half_end) state_nxt = GAP;
      GAP:     if (gap_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timing counters, shifter and registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      half      <= '0;
      len_r     <= '0;
      grant_r   <= '0;
      shreg     <= '0;
      spi_sclk  <= 1'b0;
      spi_sdata <= 1'b0;
      spi_n_en  <= '1;
    end else begin
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          half <= '0;
          if (rr_valid) begin
            grant_r   <= rr_grant;
            len_r     <= DEV_LEN[win_idx];
            shreg     <= {win_word[WORD_W-2:0], 1'b0};
            spi_sdata <= win_word[WORD_W-1];
            spi_sclk  <= 1'b0;
            spi_n_en  <= ~rr_grant;
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt      <= '0;
            half     <= 7'd1;
            spi_sclk <= 1'b1;   // first SHIFT half-period is odd: rising edge
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            cnt <= '0;
            if (last_half) begin
              spi_sclk <= 1'b0;
            end else begin
              half     <= half + 7'd1;
              spi_sclk <= ~half[0];
              // Leaving an odd half-period is a falling edge: present the next bit.
              if (half[0]) begin
                spi_sdata <= shreg[WORD_W-1];
                shreg     <= {shreg[WORD_W-2:0], 1'b0};
              end
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          if (half_end) begin
            cnt      <= '0;
            spi_n_en <= '1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (gap_end) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Completion pulse on the last enable-low cycle; busy outside IDLE.
  assign bus.done = (state == HOLD && half_end) ? grant_r : '0;
  assign bus.busy = (state != IDLE);

`ifdef IO_SPI_READBACK_EN
  localparam logic [15:0] RD_LOAD = 16'(CLK_DIV - 2);

  logic [WORD_W-1:0] rx_shreg;
  logic [WORD_W-1:0] rdata_r;
  logic              sclk_rise;

  // SCLK rises leaving SETUP and leaving every even SHIFT half-period but the last.
  assign sclk_rise = half_end &&
                     ((state == SETUP) || (state == SHIFT && !last_half && !half[0]));

  // MISO capture; the word lands in rdata so it is valid during the done cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shreg <= '0;
      rdata_r  <= '0;
    end else begin
      if (state == IDLE) begin
        rx_shreg <= '0;
      end else if (sclk_rise) begin
        rx_shreg <= {rx_shreg[WORD_W-2:0], spi_miso};
      end
      if (state == HOLD && cnt == RD_LOAD) begin
        rdata_r <= rx_shreg;
      end
    end
  end

  assign bus.rdata = rdata_r;
`else
  logic unused_miso;

  assign unused_miso = spi_miso;
  assign bus.rdata   = '0;
`endif

endmodule

// File: tb/tb_io_spi_arbiter.sv
// Scoreboard bench for io_spi_arbiter (CLK_DIV=4, CS_GAP=8). Stimulus pushes
// the expected transaction; a negedge monitor decodes each enable-low window
// on the SPI pins and compares it against the queue head.
module tb_io_spi_arbiter;
  import io_spi_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;
`ifdef IO_SPI_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef struct {
    int          dev;
    logic [31:0] word;
    logic [31:0] rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk;
  logic       spi_sdata;
  logic       spi_miso = 1'b0;
  logic [3:0] spi_n_en;

  io_spi_arbiter_if bus();

  io_spi_arbiter #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .spi_sclk  (spi_sclk),
    .spi_sdata (spi_sdata),
    .spi_miso  (spi_miso),
    .spi_n_en  (spi_n_en)
  );

  always #5 clk = ~clk;

  int          tb_len [4] = '{32, 16, 16, 32};
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q [$];
  logic [31:0] miso_word = 32'hC3A5_5A3C;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor state ----------------
  logic        in_win = 1'b0;
  logic        have_end = 1'b0;
  logic        gap_check_en = 1'b0;
  logic        en_changed;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;
  logic        busy_exp_valid = 1'b0;
  logic [3:0]  win_en;
  logic [3:0]  done_val;
  logic [3:0]  exp_en;
  logic [3:0]  exp_done;
  logic [31:0] cap;
  logic [31:0] rd_at_done;
  logic [31:0] exp_bits;
  int          low_cnt, rises, done_cnt, done_at, gap_cnt, busy_cnt, busy_exp;
  int          win_starts = 0;
  int          len, exp_low;
  exp_t        cur;

  always @(negedge clk) begin
    if (!in_win && spi_n_en != 4'hF) begin
      if (gap_check_en && have_end) check("gap_cycles", 64'(gap_cnt), 64'(CS_GAP + 1));
      in_win     = 1'b1;
      win_en     = spi_n_en;
      low_cnt    = 0;
      rises      = 0;
      cap        = '0;
      done_cnt   = 0;
      done_at    = -1;
      done_val   = '0;
      rd_at_done = '0;
      en_changed = 1'b0;
      spi_miso   = miso_word[31];
      win_starts++;
    end
    if (in_win) begin
      if (spi_n_en == 4'hF) begin
        in_win   = 1'b0;
        have_end = 1'b1;
        gap_cnt  = 1;
        if (!rst_n) begin
          check("abort_no_done", 64'(done_cnt), 64'd0);
        end else if (exp_q.size() == 0) begin
          check("unexpected_window", 64'(win_en), 64'hF);
        end else begin
          cur      = exp_q.pop_front();
          len      = tb_len[cur.dev];
          exp_en   = ~(4'b0001 << cur.dev);
          exp_done = 4'b0001 << cur.dev;
          exp_bits = cur.word >> (32 - len);
          exp_low  = CLK_DIV * (2 * len + 2);
          check("enable_select", 64'(win_en), 64'(exp_en));
          check("enable_stable", 64'(en_changed), 64'd0);
          check("enable_low_cycles", 64'(low_cnt), 64'(exp_low));
          check("sclk_rises", 64'(rises), 64'(len));
          check("mosi_bits", 64'(cap), 64'(exp_bits));
          check("done_count", 64'(done_cnt), 64'd1);
          check("done_position", 64'(done_at), 64'(exp_low));
          check("done_device", 64'(done_val), 64'(exp_done));
          check("rdata_at_done", 64'(rd_at_done), 64'(cur.rdata));
          busy_exp       = exp_low + CS_GAP;
          busy_exp_valid = 1'b1;
        end
      end else begin
        low_cnt++;
        if (spi_n_en != win_en) en_changed = 1'b1;
        if (spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
          cap = {cap[30:0], spi_sdata};
          rises++;
          spi_miso = (rises < 32) ? miso_word[31 - rises] : 1'b0;
        end
        if (bus.done != 4'b0000) begin
          done_cnt++;
          done_at    = low_cnt;
          done_val   = bus.done;
          rd_at_done = bus.rdata;
        end
      end
    end else begin
      gap_cnt++;
    end
    if (bus.busy === 1'b1) begin
      busy_cnt++;
    end else begin
      if (prev_busy === 1'b1 && rst_n && busy_exp_valid) begin
        check("busy_cycles", 64'(busy_cnt), 64'(busy_exp));
        busy_exp_valid = 1'b0;
      end
      busy_cnt = 0;
    end
    prev_busy = bus.busy;
    prev_sclk = spi_sclk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic expect_tx(input int dev);
    exp_t e;
    e.dev   = dev;
    e.word  = bus.wdata[32*dev +: 32];
    e.rdata = READBACK ? (miso_word >> (32 - tb_len[dev])) : 32'd0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((bus.busy !== 1'b0 || in_win || exp_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_within_budget", 64'(k < budget), 64'd1);
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (win_starts < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("window_start_within_budget", 64'(k < budget), 64'd1);
  endtask

  task automatic send_single(input int dev);
    logic [3:0] en_exp;
    en_exp = ~(4'b0001 << dev);
    expect_tx(dev);
    bus.req = 4'b0001 << dev;
    @(negedge clk);
    check("grant_latency", 64'(spi_n_en), 64'(en_exp));
    check("busy_with_enable", 64'(bus.busy), 64'd1);
    bus.req = 4'b0000;
    wait_idle(2000);
  endtask

  task automatic check_reset_outputs();
    check("rst_n_en", 64'(spi_n_en), 64'hF);
    check("rst_sclk", 64'(spi_sclk), 64'd0);
    check("rst_sdata", 64'(spi_sdata), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int k;
    bus.req   = 4'b0000;
    bus.wdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single ADS write, then CDCE, DAC (low bits ignored), AMC.
    bus.wdata[63:32] = 32'h0A5C_0000;
    send_single(int'(DEV_ADS));
    bus.wdata[31:0] = 32'h8F0C_A3E1;
    send_single(int'(DEV_CDCE));
    bus.wdata[95:64] = 32'hBEEF_1234;
    send_single(int'(DEV_DAC));
    bus.wdata[127:96] = 32'h5A96_0FF1;
    send_single(int'(DEV_AMC));

    // All four requesting continuously: 0,1,2,3,0 with 9-cycle gaps.
    expect_tx(0);
    expect_tx(1);
    expect_tx(2);
    expect_tx(3);
    expect_tx(0);
    s0 = win_starts;
    bus.req = 4'b1111;
    wait_starts(s0 + 1, 300);
    gap_check_en = 1'b1;
    wait_starts(s0 + 5, 2000);
    bus.req = 4'b0000;
    wait_idle(2000);
    gap_check_en = 1'b0;

    // Grant to 2, then 0 and 2 pending: 0 goes first.
    expect_tx(2);
    s0 = win_starts;
    bus.req = 4'b0100;
    wait_starts(s0 + 1, 300);
    expect_tx(0);
    expect_tx(2);
    bus.req = 4'b0101;
    wait_starts(s0 + 3, 2000);
    bus.req = 4'b0000;
    wait_idle(2000);

    // Reset around bit 5 of an AMC write; nothing expected from it.
    bus.wdata[127:96] = 32'hF00D_CAFE;
    s0 = win_starts;
    bus.req = 4'b1000;
    wait_starts(s0 + 1, 300);
    bus.req = 4'b0000;
    k = 0;
    while (rises < 6 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("reach_bit5_within_budget", 64'(k < 400), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_single(int'(DEV_AMC));

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_spi_arbiter.md
# io_spi_arbiter

Shares the single FMC151 SPI bus (spi_sclk/spi_sdata) between the four on-card SPI devices: CDCE72010 clock synth, ADS62P49 ADC, DAC3283 DAC and AMC7823 monitor. Each device's configuration sequencer posts one fixed-length write word. The arbiter grants requesters round-robin, drives the selected active-low enable, and serialises the word MSB-first. It sits in the 200 MHz system domain between the init sequencers and the card pins.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range ≥2.
- CS_GAP, 8: idle clk cycles with all enables high between transactions; legal range ≥1.

Ports:
- clk  in  1  200 MHz system clock; sole clock.
- rst_n  in  1  synchronous active-low reset.
- req  in  4  per-device request level. Index 0 CDCE, 1 ADS, 2 DAC, 3 AMC.
- wdata  in  128  four 32-bit words, left-justified; word i at [32i+31:32i].
- done  out  4  one-cycle completion pulse per device.
- busy  out  1  high in every state except IDLE.
- spi_sclk  out  1  SPI clock, CPOL=0.
- spi_sdata  out  1  MOSI.
- spi_miso  in  1  MISO (cdce_miso); used only with readback compiled in.
- spi_n_en  out  4  active-low device enables.
- rdata  out  32  captured MISO word (readback only).

## Operation
- Word lengths are fixed: CDCE 32, ADS 16, DAC 16, AMC 32. Bits [31:32-LEN] are sent MSB first. Lower bits are ignored.
- FSM states:
  - IDLE: if any req is high, grant via round-robin, latch wdata of the winner and its length, and go to SETUP.
  - SETUP: the granted spi_n_en is low and sclk is low. spi_sdata = MSB. Lasts 1 half-period, then go to SHIFT.
  - SHIFT: 2·LEN half-periods. sclk rises on odd half-periods and falls on even ones. sdata updates to the next bit on each falling edge, so the device samples on rising edges. After the last falling edge, go to HOLD.
  - HOLD: enable low, sclk low, 1 half-period. done[g] pulses on the final HOLD cycle. Then go to GAP.
  - GAP: all enables high for CS_GAP cycles, then go to IDLE.
- Round-robin:
  - The pointer starts at 0 after reset.
  - The search starts at the pointer and takes the first high req.
  - After a grant, the pointer becomes grant+1 mod 4.
- req is sampled only in IDLE. Dropping req mid-transaction does not abort the transaction. The requester holds wdata stable from req until done.
- A req held high after done is re-served only after the other pending requesters.
- Reset mid-transaction: on the next edge the FSM returns to IDLE and all outputs take their reset values. No done pulse is issued.
- Reset values: spi_sclk 0, spi_sdata 0, spi_n_en 4'hF, done 0, busy 0, rdata 0, pointer 0.

## Timing
- Grant latency: req is seen high in IDLE at edge n, and spi_n_en[g] is low from edge n+1.
- Enable-low duration is CLK_DIV·(2·LEN+2) cycles.
- Total transaction time is that duration plus CS_GAP, plus 1 IDLE cycle before the next grant.
- busy rises with the enable and falls on entry to IDLE.
- done is exactly 1 cycle wide, coincident with the last enable-low cycle.
- sclk, sdata and the enables are all registered; there is no combinational path from inputs to pins.

## Configuration
- IO_SPI_READBACK_EN:
  - Defined: spi_miso is registered on every SCLK rising edge into a shift register. rdata is updated with the LEN captured bits (right-justified, upper bits zero) on the done cycle, and holds until the next done.
  - Undefined: the capture logic is omitted, rdata is tied to 0, and spi_miso is unused.

## Structure
- The package io_spi_pkg holds:
  - device index constants (DEV_CDCE=0, DEV_ADS=1, DEV_DAC=2, DEV_AMC=3);
  - the LEN table (32, 16, 16, 32);
  - the FSM state enum (IDLE, SETUP, SHIFT, HOLD, GAP).
- One sub-module, io_spi_rr_arbiter: a 4-way round-robin grant with a pointer register. Inputs req and an advance strobe; outputs a one-hot grant and a valid flag.
- The SCLK half-period counter, the bit counter and the shifter live in io_spi_arbiter.

## Test plan
(CLK_DIV=4, CS_GAP=8)
- Single ADS write of wdata[63:32]=32'h0A5C_0000 → spi_n_en=4'b1101 for 136 cycles; 16 sclk rising edges sample 0x0A5C MSB first; done[1] pulses once; busy is high for 144 cycles.
- CDCE write 32'h8F0C_A3E1 → spi_n_en[0] low for 264 cycles; 32 bits match; done[0] is on the final enable-low cycle.
- req=4'b1111 held continuously → grants in order 0,1,2,3,0; consecutive enable-low windows are separated by 9 cycles of 4'hF.
- After a grant to 2, req=4'b0101 → 0 is served before 2.
- rst_n low at SHIFT bit 5 of an AMC write → next edge: spi_n_en=4'hF, sclk 0, busy 0, no done; a fresh req is then served from a full SETUP.
- With IO_SPI_READBACK_EN: spi_miso driven with 0xC3A5_5A3C on a CDCE write → rdata=32'hC3A5_5A3C at done. Without the macro, rdata stays 0.
